// File: rtl/fifo_unpacker_if.sv
// Handshake bundle between the FIFO read port, the unpacker and the narrow consumer.
// The master side is the unpacker; the slave side is the FIFO plus the consumer.
interface fifo_unpacker_if #(
  parameter int W_IN  = 32,
  parameter int W_OUT = 8
);
  logic [W_IN-1:0]  fifo_rdata;
  logic             fifo_empty;
  logic             fifo_ren;
  logic [W_OUT-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             busy;

  modport master (
    input  fifo_rdata, fifo_empty, out_ready,
    output fifo_ren, out_data, out_valid, out_last, busy
  );

  modport slave (
    output fifo_rdata, fifo_empty, out_ready,
    input  fifo_ren, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/fifo_unpacker.sv
// Pops W_IN-bit words from a sync FIFO and streams them out as W_OUT-bit chunks,
// LSB chunk first, on a valid/ready interface with registered outputs.
module fifo_unpacker #(
  parameter int W_IN  = 32,
  parameter int W_OUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_unpacker_if.master      bus
);
  localparam int RATIO = W_IN / W_OUT;
  localparam int IDX_W = $clog2(RATIO);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t                      state;
  logic [RATIO-1:0][W_OUT-1:0] hold;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            idx_next;
  logic [W_OUT-1:0]            data_q;
  logic                        last_q;
  logic                        accept;
  logic                        ren;

  assign accept   = (state == HOLD) && bus.out_ready;
  assign idx_next = idx + 1'b1;

  // NOTE: the pop strobe is combinational so a new word loads on the same edge
  // that retires the last chunk; gating with rst keeps the FIFO untouched in reset.
  assign ren = !rst && !bus.fifo_empty && ((state == EMPTY) || (accept && last_q));

  // NOTE: all state, including the hold register, uses non-blocking assignments
  // and is cleared by the async reset so no stale chunk survives a mid-word reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      hold   <= '0;
      idx    <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (ren) begin
      state  <= HOLD;
      hold   <= bus.fifo_rdata;
      idx    <= '0;
      data_q <= bus.fifo_rdata[W_OUT-1:0];
      last_q <= 1'b0;
    end else if (accept && !last_q) begin
      idx    <= idx_next;
      data_q <= hold[idx_next];
      last_q <= (idx_next == IDX_W'(RATIO - 1));
    end else if (accept) begin
      // Last chunk taken and nothing queued behind it.
      state  <= EMPTY;
      idx    <= '0;
      last_q <= 1'b0;
    end
  end

  assign bus.fifo_ren  = ren;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_last  = last_q;
  assign bus.busy      = (state == HOLD);
endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker (32-bit words to 8-bit chunks) with a
// behavioural FIFO and a scoreboard for the randomised soak.
module tb_fifo_unpacker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_unpacker_if #(.W_IN(32), .W_OUT(8)) bus ();

  fifo_unpacker #(.W_IN(32), .W_OUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural FIFO: pointers grow monotonically, memory wraps at 2048.
  logic [31:0] fifo_mem [0:2047];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          ren_count = 0;
  logic        hide = 1'b0;
  logic [10:0] rd_idx;

  assign rd_idx         = rd_ptr[10:0];
  assign bus.fifo_empty = (wr_ptr == rd_ptr) || hide;
  assign bus.fifo_rdata = fifo_mem[rd_idx];

  always @(posedge clk) begin
    if (bus.fifo_ren) begin
      rd_ptr    <= rd_ptr + 1;
      ren_count <= ren_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr[10:0]] = w;
    wr_ptr++;
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic last, input logic ren);
    #1;
    check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " data"},  32'(bus.out_data),  32'(d));
    check({tag, " last"},  32'(bus.out_last),  32'(last));
    check({tag, " ren"},   32'(bus.fifo_ren),  32'(ren));
  endtask

  task automatic expect_idle(input string tag);
    #1;
    check({tag, " valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " busy"},  32'(bus.busy),      32'd0);
    check({tag, " ren"},   32'(bus.fifo_ren),  32'd0);
  endtask

  // Soak scoreboard: reassemble accepted chunks and compare against pushed words.
  logic        mon_en = 1'b0;
  logic [31:0] exp_q [$];
  logic [3:0][7:0] rx_word;
  int          rx_cnt   = 0;
  int          rx_words = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("soak ren_while_empty", 32'(bus.fifo_ren && bus.fifo_empty), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        rx_word[rx_cnt] = bus.out_data;
        check("soak last_position", 32'(bus.out_last), 32'(rx_cnt == 3));
        if (rx_cnt == 3) begin
          if (exp_q.size() == 0) check("soak extra_word", 32'd1, 32'd0);
          else                   check("soak word", rx_word, exp_q.pop_front());
          rx_words++;
          rx_cnt = 0;
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  initial begin
    int base;
    bus.out_ready = 1'b0;

    // Reset state, with a word waiting that must not be popped during reset.
    #2;
    push(32'h4433_2211);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data",  32'(bus.out_data),  32'd0);
    check("reset out_last",  32'(bus.out_last),  32'd0);
    check("reset busy",      32'(bus.busy),      32'd0);
    check("reset fifo_ren",  32'(bus.fifo_ren),  32'd0);
    tick();
    tick();

    // 1: single word, consumer always ready.
    rst = 1'b0;
    bus.out_ready = 1'b1;
    base = ren_count;
    #1;
    check("t1 first ren", 32'(bus.fifo_ren), 32'd1);
    tick(); expect_beat("t1 b0", 8'h11, 1'b0, 1'b0);
    tick(); expect_beat("t1 b1", 8'h22, 1'b0, 1'b0);
    tick(); expect_beat("t1 b2", 8'h33, 1'b0, 1'b0);
    tick(); expect_beat("t1 b3", 8'h44, 1'b1, 1'b0);
    tick(); expect_idle("t1 end");
    check("t1 ren pulses", 32'(ren_count - base), 32'd1);

    // 2: two words back to back, no bubble between them.
    push(32'h4433_2211);
    push(32'h8877_6655);
    base = ren_count;
    tick(); expect_beat("t2 b0", 8'h11, 1'b0, 1'b0);
    tick(); expect_beat("t2 b1", 8'h22, 1'b0, 1'b0);
    tick(); expect_beat("t2 b2", 8'h33, 1'b0, 1'b0);
    tick(); expect_beat("t2 b3", 8'h44, 1'b1, 1'b1);
    tick(); expect_beat("t2 b4", 8'h55, 1'b0, 1'b0);
    tick(); expect_beat("t2 b5", 8'h66, 1'b0, 1'b0);
    tick(); expect_beat("t2 b6", 8'h77, 1'b0, 1'b0);
    tick(); expect_beat("t2 b7", 8'h88, 1'b1, 1'b0);
    tick(); expect_idle("t2 end");
    check("t2 ren pulses", 32'(ren_count - base), 32'd2);

    // 3: backpressure on chunk 0x22 with a second word already queued.
    push(32'h4433_2211);
    tick(); expect_beat("t3 b0", 8'h11, 1'b0, 1'b0);
    push(32'hDDCC_BBAA);
    tick();
    bus.out_ready = 1'b0;
    expect_beat("t3 stall0", 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(); expect_beat("t3 stall", 8'h22, 1'b0, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick(); expect_beat("t3 b2", 8'h33, 1'b0, 1'b0);
    tick(); expect_beat("t3 b3", 8'h44, 1'b1, 1'b1);
    tick(); expect_beat("t3 b4", 8'hAA, 1'b0, 1'b0);
    tick(); expect_beat("t3 b5", 8'hBB, 1'b0, 1'b0);
    tick(); expect_beat("t3 b6", 8'hCC, 1'b0, 1'b0);
    tick(); expect_beat("t3 b7", 8'hDD, 1'b1, 1'b0);
    tick(); expect_idle("t3 end");

    // 4: empty FIFO, random ready: nothing may happen.
    for (int i = 0; i < 20; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick(); expect_idle("t4 idle");
    end

    // 5: reset after chunk 0x22 is accepted; the rest of the word is dropped.
    bus.out_ready = 1'b1;
    push(32'h4433_2211);
    push(32'h8877_6655);
    tick(); expect_beat("t5 b0", 8'h11, 1'b0, 1'b0);
    tick(); expect_beat("t5 b1", 8'h22, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("t5 rst out_valid", 32'(bus.out_valid), 32'd0);
    check("t5 rst out_data",  32'(bus.out_data),  32'd0);
    check("t5 rst out_last",  32'(bus.out_last),  32'd0);
    check("t5 rst fifo_ren",  32'(bus.fifo_ren),  32'd0);
    tick();
    check("t5 held out_valid", 32'(bus.out_valid), 32'd0);
    check("t5 held fifo_ren",  32'(bus.fifo_ren),  32'd0);
    rst = 1'b0;
    #1;
    check("t5 release ren", 32'(bus.fifo_ren), 32'd1);
    tick(); expect_beat("t5 n0", 8'h55, 1'b0, 1'b0);
    tick(); expect_beat("t5 n1", 8'h66, 1'b0, 1'b0);
    tick(); expect_beat("t5 n2", 8'h77, 1'b0, 1'b0);
    tick(); expect_beat("t5 n3", 8'h88, 1'b1, 1'b0);
    tick(); expect_idle("t5 end");

    // 6: randomised empty/ready soak against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] w;
      w = $urandom;
      push(w);
      exp_q.push_back(w);
    end
    mon_en = 1'b1;
    begin
      int cycles;
      cycles = 0;
      while (rx_words < 1000 && cycles < 40000) begin
        hide          = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        tick();
        cycles++;
      end
    end
    hide = 1'b0;
    tick();
    mon_en = 1'b0;
    check("soak words_received", 32'(rx_words), 32'd1000);
    check("soak fifo_drained",   32'(wr_ptr - rd_ptr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
